// File: rtl/nios_sys_pio_pkg.sv
// Shared register map and edge-capture encodings for the Nios PIO/GPIO peripheral.
// Constants only; no logic.
package nios_sys_pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
    localparam logic [2:0] ADDR_OUTTGL  = 3'd6;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios_sys_pio_gpio_if.sv
// Avalon-MM slave bus for the GPIO peripheral: fixed-latency writes, combinational reads.
// No wait states, so the bus carries no backpressure signal.
interface nios_sys_pio_gpio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/nios_sys_pio_sync_edge.sv
// Pin synchroniser plus per-bit edge detector gated by a post-reset settle window.
// sync_in lags in_port by SYNC_STAGES edges; detect is combinational from the sync/prev flops.
module nios_sys_pio_sync_edge
    import nios_sys_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] detect
);

    localparam logic [2:0] SETTLE_INIT = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  prev;
    logic [2:0]                        settle;
    logic [WIDTH-1:0]                  rise;
    logic [WIDTH-1:0]                  fall;
    logic [WIDTH-1:0]                  edge_vec;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev   <= '0;
            settle <= SETTLE_INIT;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
            prev   <= sync_q[SYNC_STAGES-1];
            if (settle != 3'd0) begin
                settle <= settle - 3'd1;
            end
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];
    assign rise    = sync_in & ~prev;
    assign fall    = ~sync_in & prev;

    always_comb begin
        edge_vec = rise;
        case (EDGE_TYPE)
            EDGE_FALL: edge_vec = fall;
            EDGE_ANY:  edge_vec = rise | fall;
            default:   edge_vec = rise;
        endcase
    end

    // Pins already high at reset release would otherwise look like rising edges.
    assign detect = (settle == 3'd0) ? edge_vec : '0;

endmodule

// File: rtl/nios_sys_pio_gpio.sv
// WIDTH-bit Avalon-MM GPIO: data/dir/mask/edge-capture registers, atomic set/clear/toggle.
// Writes take effect one edge later, reads are combinational, irq registered; never stalls the bus.
module nios_sys_pio_gpio
    import nios_sys_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter int               SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    nios_sys_pio_gpio_if.slave   bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic [WIDTH-1:0]     out_port,
    output logic [WIDTH-1:0]     oe,
    output logic                 irq
);

    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] cap;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] detect;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] rd_val;
    logic             wr_en;

    nios_sys_pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .sync_in (sync_in),
        .detect  (detect)
    );

    assign wr_en   = bus.chipselect & ~bus.write_n;
    assign wd      = bus.writedata[WIDTH-1:0];
    assign cap_clr = (wr_en && (bus.address == ADDR_EDGECAP)) ? wd : '0;

    if (WIDTH < 32) begin : g_hi
        logic unused_wd_hi;
        assign unused_wd_hi = ^bus.writedata[31:WIDTH];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_reg <= RESET_OUT;
            dir     <= RESET_DIR;
            mask    <= '0;
        end else if (wr_en) begin
            case (bus.address)
                ADDR_DATA:    out_reg <= wd;
                ADDR_DIR:     dir     <= wd;
                ADDR_IRQMASK: mask    <= wd;
                ADDR_OUTSET:  out_reg <= out_reg | wd;
                ADDR_OUTCLR:  out_reg <= out_reg & ~wd;
                ADDR_OUTTGL:  out_reg <= out_reg ^ wd;
                default:      ;
            endcase
        end
    end

    // Clear is applied before OR-ing in detect so a coincident edge survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap <= '0;
            irq <= 1'b0;
        end else begin
            cap <= (cap & ~cap_clr) | detect;
            irq <= |(cap & mask);
        end
    end

    always_comb begin
        rd_val = '0;
        case (bus.address)
            ADDR_DATA:    rd_val = (dir & out_reg) | (~dir & sync_in);
            ADDR_DIR:     rd_val = dir;
            ADDR_IRQMASK: rd_val = mask;
            ADDR_EDGECAP: rd_val = cap;
            default:      rd_val = '0;
        endcase
    end

    assign bus.readdata = 32'(rd_val);
    assign out_port     = out_reg;
    assign oe           = dir;

endmodule

// File: doc/nios_sys_pio_gpio.md
Name: nios_sys_pio_gpio

Overview:
- Parametrised Avalon-MM GPIO peripheral for the Nios system. It replaces the fixed single-bit output-only PIO with a WIDTH-bit bidirectional port.
- Each bit has its own direction control. Output bits support atomic set, clear and toggle writes.
- Input bits are synchronised, and edges are captured into a sticky register with a maskable level interrupt.
- Drives motor coil, direction and enable lines; reads limit switches and encoder lines.

Parameters:
- WIDTH, 8, number of GPIO bits (1..32).
- RESET_OUT, 0, reset value of the output data register (WIDTH bits).
- RESET_DIR, 0, reset value of the direction register; 1 = output.
- EDGE_TYPE, 0, capture condition: 0 rising, 1 falling, 2 any.
- SYNC_STAGES, 2, input synchroniser depth (2..4).

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- address, input, 3, register select.
- chipselect, input, 1, slave select.
- write_n, input, 1, active-low write strobe.
- writedata, input, 32, write data.
- readdata, output, 32, read data (combinational from address).
- in_port, input, WIDTH, asynchronous pin inputs.
- out_port, output, WIDTH, output data register.
- oe, output, WIDTH, per-bit output enable (= direction register).
- irq, output, 1, level interrupt.

Behaviour:
- One clock domain: clk. Reset is asynchronous, active-low, on reset_n.
- A write occurs on a rising edge of clk with chipselect=1 and write_n=0. Only writedata[WIDTH-1:0] is used; upper bits are ignored.
- Register map (address : write effect / read value):
  - 0 DATA: write loads out_reg. Read bit i = dir[i] ? out_reg[i] : sync_in[i].
  - 1 DIR: write loads dir. Read returns dir.
  - 2 IRQMASK: write loads mask. Read returns mask.
  - 3 EDGECAP: write-1-to-clear per bit. Read returns cap.
  - 4 OUTSET: out_reg |= wd. Read returns 0.
  - 5 OUTCLR: out_reg &= ~wd. Read returns 0.
  - 6 OUTTGL: out_reg ^= wd. Read returns 0.
  - 7: reserved. Writes have no effect; reads return 0.
- readdata[31:WIDTH] is always 0.
- out_port = out_reg and oe = dir; both update one cycle after the write edge.
- Reset values:
  - out_reg = RESET_OUT, dir = RESET_DIR, mask = 0, cap = 0.
  - Synchroniser flops = 0, prev = 0, irq = 0.
  - Settle counter = SYNC_STAGES+1.
- Synchroniser: in_port passes through SYNC_STAGES flops to give sync_in. prev holds sync_in delayed by one cycle.
- Edge detect, per bit:
  - rise = sync_in & ~prev; fall = ~sync_in & prev; any = rise | fall.
  - Detection applies to every bit, including output bits.
- Latency: an in_port change is stable before clk edge k. sync_in reflects it after edge k+SYNC_STAGES-1. The cap bit sets at edge k+SYNC_STAGES.
- Settle counter:
  - Decrements each cycle after reset until it reaches 0.
  - Edge capture is suppressed while it is nonzero, so pins held high through reset do not produce false edges.
- cap update, per bit, evaluated every cycle: cap_next = (cap & ~clr) | detect.
  - A simultaneous edge and clear leaves the bit set: the edge wins.
- irq = |(cap & mask), driven from a register with one cycle latency after the cap or mask update.
- Reset asserted mid-operation: all state returns to reset values immediately. The settle window restarts on release.
- WIDTH=32: no padding. WIDTH=1 is legal and gives a superset of the legacy single-bit PIO.

Decomposition:
- Package nios_sys_pio_pkg holds:
  - register address constants ADDR_DATA .. ADDR_OUTTGL;
  - EDGE_RISE/EDGE_FALL/EDGE_ANY encodings.
- Sub-module nios_sys_pio_sync_edge (WIDTH, SYNC_STAGES, EDGE_TYPE):
  - contains the synchroniser, prev register, settle counter and detect vector;
  - outputs sync_in and detect.
- The top level holds the registers, read mux and irq.

Test Plan:
- Reset with RESET_OUT=8'hA5, RESET_DIR=8'h0F:
  - out_port=A5, oe=0F, irq=0, reads of regs 2 and 3 = 0;
  - in_port held FF through reset -> EDGECAP still 0 after 10 cycles.
- DATA write 8'h3C, then OUTSET 8'h01, OUTCLR 8'h04, OUTTGL 8'hF0:
  - out_port = 3C, 3D, 39, C9 on successive cycles;
  - writedata 32'hFFFF_FF00 to DATA -> out_port=00.
- DIR=8'h0F, out_reg=8'h55, in_port=8'hA0 -> DATA read = 32'h0000_00A5.
- EDGE_TYPE=0, mask=8'h10:
  - in_port bit4 rises -> cap=10 at edge k+2, irq=1 one cycle later;
  - bit4 falls -> no change;
  - write 10 to EDGECAP -> cap=0, irq=0 the cycle after.
- Simultaneous event: a write of 1 to EDGECAP bit3 lands on the same edge a bit3 rising edge is detected -> cap[3] stays 1.
- Reset asserted mid-stream with cap=8'hFF, mask=8'hFF, irq=1 -> immediate cap=0, irq=0, registers back to RESET_* values.
